// File: rtl/riscv_pkg.sv
// Shared core definitions: data width plus data-cache FSM states and default geometry.
package riscv_pkg;

    localparam int XLEN              = 32;
    localparam int DC_LINES          = 64;
    localparam int DC_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_REFILL,
        DC_WRITE
    } dcache_state_e;

endpackage

// File: rtl/dcache_data_ram.sv
// Data-cache word array: combinational read port, byte-enabled write port.
module dcache_data_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [3:0]      be_i
);

    genvar gi;
    generate
        // One byte-wide array per lane so each lane has its own write enable.
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            always_ff @(posedge clk) begin
                if (we_i && be_i[gi]) begin
                    lane_q[waddr_i] <= wdata_i[8*gi +: 8];
                end
            end

            assign rdata_o[8*gi +: 8] = lane_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing bus.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
    import riscv_pkg::*;
#(
    parameter int LINES          = DC_LINES,
    parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      mem_byte_en,
    input  logic            mem_rd_en,
    input  logic            mem_wr_en,
    output logic [XLEN-1:0] mem_rdata_raw,
    output logic            dcache_ready,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_misses
`endif
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TB = XLEN - 2 - WB - IB;
    localparam int AW = IB + WB;
    localparam int CW = WB + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS_PER_LINE);

    dcache_state_e   state_q;
    logic [LINES-1:0] valid_q;
    logic [TB-1:0]   tag_mem [LINES];
    logic [CW-1:0]   beat_q;
    logic [TB-1:0]   line_tag_q;
    logic [IB-1:0]   line_idx_q;
    logic            bus_req_q, bus_we_q;
    logic [XLEN-1:0] bus_addr_q, bus_wdata_q, rdata_hold_q;
    logic [3:0]      bus_be_q;

    logic [TB-1:0]   req_tag;
    logic [IB-1:0]   req_idx;
    logic [WB-1:0]   req_word;
    logic            idle, is_rd, hit, rd_hit, rd_miss, refill_ack;
    logic [XLEN-1:0] ram_rdata;
    logic            unused_offset;

    assign req_tag  = mem_addr[XLEN-1 -: TB];
    assign req_idx  = mem_addr[2+WB +: IB];
    assign req_word = mem_addr[2 +: WB];
    assign unused_offset = ^mem_addr[1:0];

    assign idle       = (state_q == DC_IDLE);
    assign is_rd      = mem_rd_en && !mem_wr_en;
    assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_hit     = idle && is_rd && hit;
    assign rd_miss    = idle && is_rd && !hit;
    assign refill_ack = (state_q == DC_REFILL) && bus_req_q && bus_ack;

    dcache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (AW)
    ) u_data_ram (
        .clk     (clk),
        .raddr_i ({req_idx, req_word}),
        .rdata_o (ram_rdata),
        .we_i    (refill_ack || (idle && mem_wr_en && hit)),
        .waddr_i (refill_ack ? {line_idx_q, beat_q[WB-1:0]} : {req_idx, req_word}),
        .wdata_i (refill_ack ? bus_rdata : mem_wdata),
        .be_i    (refill_ack ? 4'hF : mem_byte_en)
    );

    // Tags need no reset: a line is never looked up while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (rd_miss) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= DC_IDLE;
            valid_q      <= '0;
            beat_q       <= '0;
            line_tag_q   <= '0;
            line_idx_q   <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            rdata_hold_q <= '0;
        end else begin
            if (rd_hit) begin
                rdata_hold_q <= ram_rdata;
            end
            case (state_q)
                DC_IDLE: begin
                    if (mem_wr_en) begin
                        state_q     <= DC_WRITE;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= {mem_addr[XLEN-1:2], 2'b00};
                        bus_wdata_q <= mem_wdata;
                        bus_be_q    <= mem_byte_en;
                    end else if (rd_miss) begin
                        valid_q[req_idx] <= 1'b0;
                        line_tag_q       <= req_tag;
                        line_idx_q       <= req_idx;
                        beat_q           <= '0;
                        state_q          <= DC_REFILL;
                    end
                end
                // Each beat is a request cycle followed by a one-cycle gap; the gap
                // after the final beat marks the line valid.
                DC_REFILL: begin
                    if (!bus_req_q) begin
                        if (beat_q == LAST_BEAT) begin
                            valid_q[line_idx_q] <= 1'b1;
                            state_q             <= DC_IDLE;
                        end else begin
                            bus_req_q  <= 1'b1;
                            bus_we_q   <= 1'b0;
                            bus_addr_q <= {line_tag_q, line_idx_q, beat_q[WB-1:0], 2'b00};
                        end
                    end else if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        beat_q    <= beat_q + CW'(1);
                    end
                end
                DC_WRITE: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        state_q   <= DC_IDLE;
                    end
                end
                default: state_q <= DC_IDLE;
            endcase
        end
    end

    assign dcache_ready  = reset && ((idle && !mem_rd_en && !mem_wr_en) || rd_hit ||
                                     ((state_q == DC_WRITE) && bus_ack));
    assign mem_rdata_raw = rd_hit ? ram_rdata : rdata_hold_q;
    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q;
    logic        refill_done_q;

    // The lookup in the cycle right after a refill is the held load re-hitting, not a new load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            refill_done_q <= 1'b0;
        end else begin
            refill_done_q <= (state_q == DC_REFILL) && !bus_req_q && (beat_q == LAST_BEAT);
            if (rd_hit && !refill_done_q) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (rd_miss) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: zero-wait backing memory model, beat log, hand-computed expectations.
module tb_dcache;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     mem_addr = '0, mem_wdata = '0;
    logic [3:0]      mem_byte_en = '0;
    logic            mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [31:0]     mem_rdata_raw;
    logic            dcache_ready;
    logic            bus_req, bus_we;
    logic [31:0]     bus_addr, bus_wdata;
    logic [3:0]      bus_be;
    logic            bus_ack = 1'b0;
    logic [31:0]     bus_rdata = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0]     stat_hits, stat_misses;
`endif

    int              n_checks = 0;
    int              n_fail = 0;
    logic [31:0]     mem [0:4095];
    logic [31:0]     log_addr[$];
    logic            log_we[$];
    logic [3:0]      log_be[$];

    dcache dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_byte_en   (mem_byte_en),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .mem_rdata_raw (mem_rdata_raw),
        .dcache_ready  (dcache_ready),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory: acks every requested beat within the same cycle.
    always @(posedge clk) begin
        #2;
        if (bus_req) begin
            bus_ack = 1'b1;
            if (bus_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus_be[b]) mem[bus_addr[13:2]][8*b +: 8] = bus_wdata[8*b +: 8];
            end else begin
                bus_rdata = mem[bus_addr[13:2]];
            end
            log_addr.push_back(bus_addr);
            log_we.push_back(bus_we);
            log_be.push_back(bus_be);
        end else begin
            bus_ack = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int lat);
        bit seen;
        seen = 1'b0;
        rdata = '0;
        lat = 0;
        @(posedge clk);
        #1;
        log_addr.delete();
        log_we.delete();
        log_be.delete();
        mem_addr = addr;
        mem_wdata = wdata;
        mem_byte_en = be;
        mem_rd_en = !wr;
        mem_wr_en = wr;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (dcache_ready) begin
                seen = 1'b1;
                rdata = mem_rdata_raw;
            end else begin
                lat++;
            end
        end
        check_eq("ready_seen", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        $display("%s addr=%h lat=%0d rdata=%h beats=%0d", wr ? "WR" : "RD", addr, lat, rdata,
                 log_addr.size());
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cnt;

        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
        mem[12'h040] = 32'h11;
        mem[12'h041] = 32'h22;
        mem[12'h042] = 32'h33;
        mem[12'h043] = 32'h44;

        #12;
        check_eq("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check_eq("rst_ready", {31'b0, dcache_ready}, 32'd0);
        check_eq("rst_rdata", mem_rdata_raw, 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cold read of 0x100 fills the line, then a hit on 0x108.
        access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check_eq("s1_lat", 32'(lat), 32'd10);
        check_eq("s1_data", rd, 32'h11);
        check_eq("s1_beats", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            check_eq($sformatf("s1_beat%0d_addr", i), log_addr[i], 32'h100 + 32'(4*i));
        if (log_we.size() > 0) check_eq("s1_beat_we", {31'b0, log_we[0]}, 32'd0);
        access(1'b0, 32'h108, 32'h0, 4'h0, rd, lat);
        check_eq("s1_hit_lat", 32'(lat), 32'd0);
        check_eq("s1_hit_data", rd, 32'h33);
        check_eq("s1_hit_beats", 32'(log_addr.size()), 32'd0);
        #3;
        check_eq("s1_hold", mem_rdata_raw, 32'h33);
`ifdef DCACHE_STATS_EN
        check_eq("stat_misses", stat_misses, 32'd1);
        check_eq("stat_hits", stat_hits, 32'd1);
`endif

        // Byte store hitting the cached line.
        access(1'b1, 32'h104, 32'h0000AB00, 4'b0010, rd, lat);
        check_eq("s2_lat", 32'(lat), 32'd1);
        check_eq("s2_beats", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() > 0) begin
            check_eq("s2_addr", log_addr[0], 32'h104);
            check_eq("s2_be", {28'b0, log_be[0]}, 32'h2);
            check_eq("s2_we", {31'b0, log_we[0]}, 32'd1);
        end
        access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
        check_eq("s2_rd_lat", 32'(lat), 32'd0);
        check_eq("s2_rd_data", rd, 32'h0000AB22);

        // Store miss does not allocate.
        access(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, rd, lat);
        check_eq("s3_beats", 32'(log_addr.size()), 32'd1);
        check_eq("s3_lat", 32'(lat), 32'd1);
        access(1'b0, 32'h2000, 32'h0, 4'h0, rd, lat);
        check_eq("s3_rd_lat", 32'(lat), 32'd10);
        check_eq("s3_rd_data", rd, 32'hDEADBEEF);
        if (log_addr.size() > 0) check_eq("s3_first_beat", log_addr[0], 32'h2000);

        // Conflict: 0x500 shares the index of 0x100.
        access(1'b0, 32'h500, 32'h0, 4'h0, rd, lat);
        check_eq("s4_lat", 32'(lat), 32'd10);
        check_eq("s4_data", rd, 32'hA0000140);
        if (log_addr.size() == 4) begin
            check_eq("s4_beat0", log_addr[0], 32'h500);
            check_eq("s4_beat3", log_addr[3], 32'h50C);
        end
        access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check_eq("s4_reread_lat", 32'(lat), 32'd10);
        check_eq("s4_reread_data", rd, 32'h11);

        // Reset during the third refill beat of a miss on 0x200.
        @(posedge clk);
        #1;
        log_addr.delete();
        log_we.delete();
        log_be.delete();
        mem_addr = 32'h200;
        mem_rd_en = 1'b1;
        cnt = 0;
        while (log_addr.size() < 3 && cnt < 100) begin
            @(posedge clk);
            #3;
            cnt++;
        end
        check_eq("s5_third_beat", 32'(log_addr.size()), 32'd3);
        check_eq("s5_req_before", {31'b0, bus_req}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("s5_req_dropped", {31'b0, bus_req}, 32'd0);
        check_eq("s5_ready_rst", {31'b0, dcache_ready}, 32'd0);
        mem_rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        check_eq("s5_rd_lat", 32'(lat), 32'd10);
        check_eq("s5_rd_data", rd, 32'h11);
        if (log_addr.size() > 0) check_eq("s5_first_beat", log_addr[0], 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
